register_file_2w2r: RTL and testbench



---
 rtl/register_file_2w2r_pkg.sv | 12 +
 rtl/register_file_2w2r_if.sv | 37 +++
 rtl/register_file_2w2r_read_port.sv | 51 +++++
 rtl/register_file_2w2r.sv | 100 ++++++++++
 tb/tb_register_file_2w2r.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/register_file_2w2r_pkg.sv
// regfile_pkg: constants shared by the register file, decode and writeback.
//   RF_DATA_W    - default register width in bits
//   RF_ADDR_W    - default address width (DEPTH = 2**RF_ADDR_W)
//   RF_ZERO_ADDR - address of the optionally hardwired zero register
// No ports; imported with import regfile_pkg::*.
package regfile_pkg;

  localparam int RF_DATA_W    = 16;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_ZERO_ADDR = 0;

endpackage : regfile_pkg

// File: rtl/register_file_2w2r_if.sv
// register_file_2w2r_if: bus between decode/writeback (master) and the
// register file (slave).
//   Ra, Rb        read addresses           (master -> slave)
//   busA, busB    combinational read data  (slave -> master)
//   wrEn0/Rw0/busW0  write port 0          (master -> slave)
//   wrEn1/Rw1/busW1  write port 1, wins on same-address writes
//   wrConflict    registered same-address dual-write flag (slave -> master)
interface register_file_2w2r_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);

  logic [ADDR_W-1:0] Ra;
  logic [ADDR_W-1:0] Rb;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic              wrEn0;
  logic [ADDR_W-1:0] Rw0;
  logic [DATA_W-1:0] busW0;
  logic              wrEn1;
  logic [ADDR_W-1:0] Rw1;
  logic [DATA_W-1:0] busW1;
  logic              wrConflict;

  modport master (
    output Ra, Rb, wrEn0, Rw0, busW0, wrEn1, Rw1, busW1,
    input  busA, busB, wrConflict
  );

  modport slave (
    input  Ra, Rb, wrEn0, Rw0, busW0, wrEn1, Rw1, busW1,
    output busA, busB, wrConflict
  );

endinterface : register_file_2w2r_if

// File: rtl/register_file_2w2r_read_port.sv
// regfile_read_port: one combinational read port of the register file.
// Selects between stored data and same-cycle write data (bypass), then
// applies zero-register and reset gating.
//   i_rst        reset; forces the output to 0 and suppresses bypass
//   i_rd_addr    read address
//   i_mem_data   stored contents at i_rd_addr
//   i_wr_en0/i_wr_addr0/i_wr_data0  write port 0 snoop
//   i_wr_en1/i_wr_addr1/i_wr_data1  write port 1 snoop (higher priority)
//   o_data       read data
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wr_en0,
  input  logic [ADDR_W-1:0] i_wr_addr0,
  input  logic [DATA_W-1:0] i_wr_data0,
  input  logic              i_wr_en1,
  input  logic [ADDR_W-1:0] i_wr_addr1,
  input  logic [DATA_W-1:0] i_wr_data1,
  output logic [DATA_W-1:0] o_data
);

  logic w_hit0;
  logic w_hit1;
  logic w_zero_addr;

  assign w_hit0      = i_wr_en0 && (i_wr_addr0 == i_rd_addr);
  assign w_hit1      = i_wr_en1 && (i_wr_addr1 == i_rd_addr);
  assign w_zero_addr = ZERO_REG && (i_rd_addr == ADDR_W'(RF_ZERO_ADDR));

  // Port 1 is evaluated last so it overrides port 0 on a double hit,
  // mirroring the commit priority of the storage array.
  always_comb begin
    o_data = i_mem_data;
    if (BYPASS) begin
      if (w_hit0) o_data = i_wr_data0;
      if (w_hit1) o_data = i_wr_data1;
    end
    // Gating last: zero register and reset win over any bypassed value.
    if (w_zero_addr) o_data = '0;
    if (i_rst)       o_data = '0;
  end

endmodule : regfile_read_port

// File: rtl/register_file_2w2r.sv
// register_file_2w2r: 2**ADDR_W x DATA_W register file, two write ports
// (port 1 wins on same address), two combinational read ports with optional
// same-cycle write bypass and optional hardwired zero register.
//   clk   rising-edge clock
//   rst   synchronous active-high reset; clears storage and wrConflict,
//         forces read data to 0 while high
//   bus   register_file_2w2r_if.slave (read/write ports, wrConflict)
module register_file_2w2r
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  register_file_2w2r_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_conflict;

  logic              w_we0;
  logic              w_we1;
  logic              w_conflict;
  logic [DATA_W-1:0] w_mem_a;
  logic [DATA_W-1:0] w_mem_b;

  // Writes aimed at the hardwired zero register are dropped before they
  // reach storage, bypass, or conflict detection.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == ADDR_W'(RF_ZERO_ADDR));
  endfunction

  assign w_we0      = bus.wrEn0 && !is_zero_reg(bus.Rw0);
  assign w_we1      = bus.wrEn1 && !is_zero_reg(bus.Rw1);
  assign w_conflict = w_we0 && w_we1 && (bus.Rw0 == bus.Rw1);

  // Storage: port 1 is assigned after port 0, so on a shared address its
  // data is the one that commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_we0) r_mem[bus.Rw0] <= bus.busW0;
      if (w_we1) r_mem[bus.Rw1] <= bus.busW1;
    end
  end

  // Conflict flag: one-cycle pulse following each offending edge.
  always_ff @(posedge clk) begin
    if (rst) r_wr_conflict <= 1'b0;
    else     r_wr_conflict <= w_conflict;
  end

  assign bus.wrConflict = r_wr_conflict;

  assign w_mem_a = r_mem[bus.Ra];
  assign w_mem_b = r_mem[bus.Rb];

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_read_a (
    .i_rst      (rst),
    .i_rd_addr  (bus.Ra),
    .i_mem_data (w_mem_a),
    .i_wr_en0   (w_we0),
    .i_wr_addr0 (bus.Rw0),
    .i_wr_data0 (bus.busW0),
    .i_wr_en1   (w_we1),
    .i_wr_addr1 (bus.Rw1),
    .i_wr_data1 (bus.busW1),
    .o_data     (bus.busA)
  );

  regfile_read_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_read_b (
    .i_rst      (rst),
    .i_rd_addr  (bus.Rb),
    .i_mem_data (w_mem_b),
    .i_wr_en0   (w_we0),
    .i_wr_addr0 (bus.Rw0),
    .i_wr_data0 (bus.busW0),
    .i_wr_en1   (w_we1),
    .i_wr_addr1 (bus.Rw1),
    .i_wr_data1 (bus.busW1),
    .o_data     (bus.busB)
  );

endmodule : register_file_2w2r

// File: tb/tb_register_file_2w2r.sv
// Directed bench for register_file_2w2r. Four builds run side by side:
//   dut_a : 16x32, ZERO_REG=0, BYPASS=1
//   dut_b : 16x32, ZERO_REG=0, BYPASS=0
//   dut_z : 16x32, ZERO_REG=1, BYPASS=1
//   dut_w : 32x8,  ZERO_REG=0, BYPASS=1
// dut_a/b/z share one stimulus; dut_w is driven separately.
module tb_register_file_2w2r;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  Ra, Rb, Rw0, Rw1;
  logic [15:0] busW0, busW1;
  logic        wrEn0, wrEn1;

  int checks = 0;
  int fails  = 0;

  register_file_2w2r_if #(.DATA_W(16), .ADDR_W(5)) if_a ();
  register_file_2w2r_if #(.DATA_W(16), .ADDR_W(5)) if_b ();
  register_file_2w2r_if #(.DATA_W(16), .ADDR_W(5)) if_z ();
  register_file_2w2r_if #(.DATA_W(32), .ADDR_W(3)) if_w ();

  assign if_a.Ra = Ra;  assign if_a.Rb = Rb;  assign if_a.wrEn0 = wrEn0;
  assign if_a.Rw0 = Rw0; assign if_a.busW0 = busW0; assign if_a.wrEn1 = wrEn1;
  assign if_a.Rw1 = Rw1; assign if_a.busW1 = busW1;
  assign if_b.Ra = Ra;  assign if_b.Rb = Rb;  assign if_b.wrEn0 = wrEn0;
  assign if_b.Rw0 = Rw0; assign if_b.busW0 = busW0; assign if_b.wrEn1 = wrEn1;
  assign if_b.Rw1 = Rw1; assign if_b.busW1 = busW1;
  assign if_z.Ra = Ra;  assign if_z.Rb = Rb;  assign if_z.wrEn0 = wrEn0;
  assign if_z.Rw0 = Rw0; assign if_z.busW0 = busW0; assign if_z.wrEn1 = wrEn1;
  assign if_z.Rw1 = Rw1; assign if_z.busW1 = busW1;

  register_file_2w2r #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  register_file_2w2r #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));
  register_file_2w2r #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut_z (.clk(clk), .rst(rst), .bus(if_z));
  register_file_2w2r #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b1))
    dut_w (.clk(clk), .rst(rst), .bus(if_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    Ra = '0; Rb = '0; Rw0 = '0; Rw1 = '0; busW0 = '0; busW1 = '0;
    wrEn0 = 1'b0; wrEn1 = 1'b0;
    if_w.Ra = '0; if_w.Rb = '0; if_w.wrEn0 = 1'b0; if_w.Rw0 = '0;
    if_w.busW0 = '0; if_w.wrEn1 = 1'b0; if_w.Rw1 = '0; if_w.busW1 = '0;
    #1;
    // Outputs forced low while rst is high, even before storage is cleared.
    chk("rst_init_busA", if_a.busA, 32'h0);
    chk("rst_init_busB", if_a.busB, 32'h0);
    tick();
    tick();
    chk("rst_conflict", if_a.wrConflict, 32'h0);

    // Write 547 to r1, then reset with a pending write to r5.
    rst = 1'b0; wrEn0 = 1'b1; Rw0 = 5'd1; busW0 = 16'd547; Ra = 5'd1;
    tick();
    wrEn0 = 1'b0; #1;
    chk("r1_547", if_a.busA, 32'd547);
    rst = 1'b1; wrEn1 = 1'b1; Rw1 = 5'd5; busW1 = 16'd99; Rb = 5'd5; #1;
    chk("rst_hold_busA", if_a.busA, 32'h0);
    chk("rst_no_bypass", if_a.busB, 32'h0);
    tick();
    rst = 1'b0; wrEn1 = 1'b0; #1;
    chk("post_rst_r1", if_a.busA, 32'h0);
    chk("post_rst_r5", if_a.busB, 32'h0);
    chk("post_rst_conflict", if_a.wrConflict, 32'h0);

    // Dual write to different addresses on one edge.
    wrEn0 = 1'b1; Rw0 = 5'd1; busW0 = 16'hFD75;
    wrEn1 = 1'b1; Rw1 = 5'd2; busW1 = 16'd4576;
    tick();
    wrEn0 = 1'b0; wrEn1 = 1'b0; Ra = 5'd1; Rb = 5'd2; #1;
    chk("dual_r1", if_a.busA, 32'h0000FD75);
    chk("dual_r2", if_a.busB, 32'h000011E0);
    chk("dual_r1_nobyp", if_b.busA, 32'h0000FD75);
    chk("dual_conflict", if_a.wrConflict, 32'h0);

    // Same-address dual write to r31: port 1 wins, one-cycle conflict pulse.
    wrEn0 = 1'b1; Rw0 = 5'd31; busW0 = 16'd32767;
    wrEn1 = 1'b1; Rw1 = 5'd31; busW1 = 16'd8; Ra = 5'd31; #1;
    chk("conf_bypass_prio", if_a.busA, 32'd8);
    chk("conf_nobyp_old", if_b.busA, 32'h0);
    chk("conf_pre_flag", if_a.wrConflict, 32'h0);
    tick();
    wrEn0 = 1'b0; wrEn1 = 1'b0; #1;
    chk("conf_r31", if_a.busA, 32'd8);
    chk("conf_r31_nobyp", if_b.busA, 32'd8);
    chk("conf_flag", if_a.wrConflict, 32'h1);
    chk("conf_flag_b", if_b.wrConflict, 32'h1);
    tick();
    chk("conf_flag_clear", if_a.wrConflict, 32'h0);

    // Bypass on r10: port 0 alone, then port 1 overriding it.
    Ra = 5'd10; wrEn0 = 1'b1; Rw0 = 5'd10; busW0 = 16'd7; #1;
    chk("byp_port0", if_a.busA, 32'd7);
    chk("nobyp_port0", if_b.busA, 32'h0);
    wrEn1 = 1'b1; Rw1 = 5'd10; busW1 = 16'd14; #1;
    chk("byp_port1", if_a.busA, 32'd14);
    chk("nobyp_port1", if_b.busA, 32'h0);
    tick();
    wrEn0 = 1'b0; wrEn1 = 1'b0; #1;
    chk("byp_after", if_a.busA, 32'd14);
    chk("nobyp_after", if_b.busA, 32'd14);

    // Zero register: both ports write 976 to r0.
    Ra = 5'd0; wrEn0 = 1'b1; Rw0 = 5'd0; busW0 = 16'd976;
    wrEn1 = 1'b1; Rw1 = 5'd0; busW1 = 16'd976; #1;
    chk("zero_no_bypass", if_z.busA, 32'h0);
    chk("nz_bypass", if_a.busA, 32'd976);
    tick();
    wrEn0 = 1'b0; wrEn1 = 1'b0; #1;
    chk("zero_r0", if_z.busA, 32'h0);
    chk("zero_conflict", if_z.wrConflict, 32'h0);
    chk("nz_r0", if_a.busA, 32'd976);
    chk("nz_conflict", if_a.wrConflict, 32'h1);

    // Wide/shallow build: r7 <- 0xDEADBEEF, r0..r6 untouched.
    if_w.wrEn0 = 1'b1; if_w.Rw0 = 3'd7; if_w.busW0 = 32'hDEADBEEF;
    tick();
    if_w.wrEn0 = 1'b0; if_w.Ra = 3'd7; if_w.Rb = 3'd0; #1;
    chk("w_r7", if_w.busA, 32'hDEADBEEF);
    chk("w_r0_b", if_w.busB, 32'h0);
    for (int i = 0; i < 7; i++) begin
      if_w.Ra = 3'(i); #1;
      chk($sformatf("w_r%0d", i), if_w.busA, 32'h0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule : tb_register_file_2w2r
